// File: rtl/pe_tile_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pe_tile_scheduler
// Function : Walks a (2*ROW_PAIRS)x(2*COL_PAIRS) output matrix tile by tile
//            through a 2x2 PE array and hands each tile out over valid/ready.
// Revision : 1.0
// ============================================================================
module pe_tile_scheduler #(
    parameter int WIDTH     = 8,
    parameter int ROW_PAIRS = 2,
    parameter int COL_PAIRS = 2,
    parameter int IDX_W     = 4
) (
    input  logic                 clk,
    input  logic                 _reset,
    input  logic                 start,
    input  logic                 cal_importance,
    output logic                 arr_rst_n,
    output logic                 arr_en,
    output logic                 arr_cal_imp,
    input  logic                 arr_done,
    input  logic [8*WIDTH-1:0]   arr_res,
    input  logic [2*WIDTH-1:0]   arr_imp,
    output logic [IDX_W-1:0]     tile_row,
    output logic [IDX_W-1:0]     tile_col,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [8*WIDTH-1:0]   res_data,
    output logic [2*WIDTH-1:0]   res_imp,
    output logic [IDX_W-1:0]     res_row,
    output logic [IDX_W-1:0]     res_col,
    output logic                 busy,
    output logic                 job_done,
    output logic                 err
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_CLEAR = 3'd1;
    localparam logic [2:0] c_RUN   = 3'd2;
    localparam logic [2:0] c_WAIT  = 3'd3;
    localparam logic [2:0] c_OUT   = 3'd4;

    localparam logic [IDX_W-1:0] c_LAST_ROW = IDX_W'(ROW_PAIRS - 1);
    localparam logic [IDX_W-1:0] c_LAST_COL = IDX_W'(COL_PAIRS - 1);
    localparam logic [2:0]       c_RUN_LAST = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         r_run_cnt;
    logic               r_arr_rst_n;
    logic               r_arr_en;
    logic               r_cal_imp;
    logic [IDX_W-1:0]   r_row;
    logic [IDX_W-1:0]   r_col;
    logic               r_res_valid;
    logic [8*WIDTH-1:0] r_res_data;
    logic [2*WIDTH-1:0] r_res_imp;
    logic [IDX_W-1:0]   r_res_row;
    logic [IDX_W-1:0]   r_res_col;
    logic               r_job_done;
    logic               r_err;

    logic               w_accept;
    logic               w_last_tile;

    assign w_accept    = r_res_valid && res_ready;
    assign w_last_tile = (r_row == c_LAST_ROW) && (r_col == c_LAST_COL);

    always_ff @(posedge clk or posedge _reset) begin
        if (_reset) begin
            r_state     <= c_IDLE;
            r_run_cnt   <= 3'd0;
            r_arr_rst_n <= 1'b1;
            r_arr_en    <= 1'b0;
            r_cal_imp   <= 1'b0;
            r_row       <= '0;
            r_col       <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_imp   <= '0;
            r_res_row   <= '0;
            r_res_col   <= '0;
            r_job_done  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_job_done  <= 1'b0;
            r_arr_rst_n <= 1'b1;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_state     <= c_CLEAR;
                        r_row       <= '0;
                        r_col       <= '0;
                        r_err       <= 1'b0;
                        r_cal_imp   <= cal_importance;
                        r_arr_rst_n <= 1'b0;
                    end
                end
                c_CLEAR: begin
                    r_state   <= c_RUN;
                    r_arr_en  <= 1'b1;
                    r_run_cnt <= 3'd0;
                end
                c_RUN: begin
                    // Enable must drop before the array raises done, else it re-runs.
                    if (r_run_cnt == c_RUN_LAST) begin
                        r_arr_en <= 1'b0;
                        r_state  <= c_WAIT;
                    end else begin
                        r_run_cnt <= r_run_cnt + 3'd1;
                    end
                end
                c_WAIT: begin
                    if (arr_done) begin
                        r_res_data  <= arr_res;
                        r_res_imp   <= r_cal_imp ? arr_imp : '0;
                        r_res_row   <= r_row;
                        r_res_col   <= r_col;
                        r_res_valid <= 1'b1;
                        r_state     <= c_OUT;
                    end else begin
                        r_err   <= 1'b1;
                        r_state <= c_IDLE;
                    end
                end
                c_OUT: begin
                    if (w_accept) begin
                        r_res_valid <= 1'b0;
                        if (w_last_tile) begin
                            r_state    <= c_IDLE;
                            r_job_done <= 1'b1;
                        end else begin
                            if (r_col == c_LAST_COL) begin
                                r_col <= '0;
                                r_row <= r_row + IDX_W'(1);
                            end else begin
                                r_col <= r_col + IDX_W'(1);
                            end
                            r_arr_rst_n <= 1'b0;
                            r_state     <= c_CLEAR;
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign arr_rst_n   = r_arr_rst_n;
    assign arr_en      = r_arr_en;
    assign arr_cal_imp = r_cal_imp;
    assign tile_row    = r_row;
    assign tile_col    = r_col;
    assign res_valid   = r_res_valid;
    assign res_data    = r_res_data;
    assign res_imp     = r_res_imp;
    assign res_row     = r_res_row;
    assign res_col     = r_res_col;
    assign busy        = (r_state != c_IDLE);
    assign job_done    = r_job_done;
    assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pe_tile_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pe_tile_scheduler
// Function : Scoreboard bench for pe_tile_scheduler with a behavioural 2x2 array.
// Revision : 1.0
// ============================================================================
module tb_pe_tile_scheduler;

    localparam int W  = 8;
    localparam int RP = 2;
    localparam int CP = 2;
    localparam int IW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            cal_importance;
    logic            arr_rst_n;
    logic            arr_en;
    logic            arr_cal_imp;
    logic            arr_done = 1'b0;
    logic [8*W-1:0]  arr_res;
    logic [2*W-1:0]  arr_imp;
    logic [IW-1:0]   tile_row;
    logic [IW-1:0]   tile_col;
    logic            res_valid;
    logic            res_ready;
    logic [8*W-1:0]  res_data;
    logic [2*W-1:0]  res_imp;
    logic [IW-1:0]   res_row;
    logic [IW-1:0]   res_col;
    logic            busy;
    logic            job_done;
    logic            err;

    always #5 clk = ~clk;

    pe_tile_scheduler #(.WIDTH(W), .ROW_PAIRS(RP), .COL_PAIRS(CP), .IDX_W(IW)) dut (
        .clk(clk), ._reset(rst), .start(start), .cal_importance(cal_importance),
        .arr_rst_n(arr_rst_n), .arr_en(arr_en), .arr_cal_imp(arr_cal_imp),
        .arr_done(arr_done), .arr_res(arr_res), .arr_imp(arr_imp),
        .tile_row(tile_row), .tile_col(tile_col), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .res_imp(res_imp),
        .res_row(res_row), .res_col(res_col), .busy(busy),
        .job_done(job_done), .err(err)
    );

    // Operand matrices: A is M x K, B is K x N.
    int A [4][4];
    int B [4][4];

    typedef struct {
        logic [63:0] data;
        logic [15:0] imp;
        logic [3:0]  row;
        logic [3:0]  col;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Behavioural PE array: 4 accumulate steps, a 5th idle step, then done.
    int  acc [4];
    int  imp_acc = 0;
    int  acnt = 0;
    bit  suppress_done = 0;
    always @(posedge clk) begin
        if (arr_rst_n === 1'b0) begin
            for (int i = 0; i < 4; i++) acc[i] = 0;
            imp_acc = 0;
            acnt = 0;
            arr_done <= 1'b0;
        end else begin
            arr_done <= 1'b0;
            if (arr_en === 1'b1) begin
                if (acnt == 4) begin
                    acnt = 0;
                    arr_done <= !suppress_done;
                end else begin
                    for (int i = 0; i < 2; i++)
                        for (int j = 0; j < 2; j++) begin
                            int p;
                            p = A[2*int'(tile_row)+i][acnt] * B[acnt][2*int'(tile_col)+j];
                            acc[2*i+j] += p;
                            imp_acc += p;
                        end
                    acnt++;
                end
            end
        end
    end
    assign arr_res = {16'(acc[3]), 16'(acc[2]), 16'(acc[1]), 16'(acc[0])};
    assign arr_imp = 16'(imp_acc);

    // Reference: each tile is a plain 2x2 slice of A*B.
    task automatic push_job(input bit cal);
        for (int tr = 0; tr < RP; tr++)
            for (int tc = 0; tc < CP; tc++) begin
                exp_t e;
                int   isum;
                isum = 0;
                e.data = '0;
                for (int i = 0; i < 2; i++)
                    for (int j = 0; j < 2; j++) begin
                        int c;
                        c = 0;
                        for (int k = 0; k < 4; k++) c += A[2*tr+i][k] * B[k][2*tc+j];
                        e.data[16*(2*i+j) +: 16] = 16'(c);
                        isum += c;
                    end
                e.imp = cal ? 16'(isum) : 16'h0;
                e.row = 4'(tr);
                e.col = 4'(tc);
                exp_q.push_back(e);
            end
    endtask

    task automatic rand_mats();
        for (int m = 0; m < 4; m++)
            for (int k = 0; k < 4; k++) begin
                A[m][k] = int'($urandom_range(0, 255)) - 128;
                B[k][m] = int'($urandom_range(0, 255)) - 128;
            end
    endtask

    // Monitor: pops the scoreboard on every handshake and checks stall stability.
    bit          stalled = 0;
    logic [63:0] h_data;
    logic [15:0] h_imp;
    logic [3:0]  h_row, h_col;
    int          en_run = 0;
    int          jd_count = 0;
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            stalled = 0;
            en_run  = 0;
        end else begin
            if (res_valid && stalled) begin
                chk("stall_data", res_data, h_data);
                chk("stall_imp", 64'(res_imp), 64'(h_imp));
                chk("stall_idx", 64'({res_row, res_col}), 64'({h_row, h_col}));
            end
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_tile: got row %0d col %0d expected none", res_row, res_col);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("tile_idx", 64'({res_row, res_col}), 64'({e.row, e.col}));
                    chk("tile_data", res_data, e.data);
                    chk("tile_imp", 64'(res_imp), 64'(e.imp));
                end
            end
            stalled = res_valid && !res_ready;
            h_data = res_data; h_imp = res_imp; h_row = res_row; h_col = res_col;
            if (!arr_rst_n) en_run = 0;
            else if (arr_en) en_run++;
            if (arr_done) begin
                chk("en_cycles", 64'(en_run), 64'd5);
                chk("en_low_at_done", 64'(arr_en), 64'd0);
                en_run = 0;
            end
            if (job_done) jd_count++;
        end
    end

    // res_ready driver: 0 always high, 1 random, 2 stall on tile (0,1) until released.
    int ready_mode = 0;
    bit release_stall = 0;
    initial begin
        res_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       res_ready = ($urandom_range(0, 3) != 0);
                2:       res_ready = release_stall || !(res_valid && res_row == 4'd0 && res_col == 4'd1);
                default: res_ready = 1'b1;
            endcase
        end
    end

    // Noise on start / cal_importance while busy; both must be ignored.
    bit start_noise = 0;
    bit cal_noise = 0;
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (start_noise && busy)
                start = (tile_row == 4'(RP-1) && tile_col == 4'(CP-1)) ? 1'b0 : 1'($urandom_range(0, 1));
            if (cal_noise && busy)
                cal_importance = ~cal_importance;
        end
    end

    task automatic do_start(input bit cal);
        @(posedge clk);
        #1;
        start = 1'b1;
        cal_importance = cal;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_job_done(input string tag);
        int n;
        n = 0;
        while (!job_done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_job_done_seen"}, 64'(job_done), 64'd1);
        chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        @(negedge clk);
        chk({tag, "_job_done_pulse"}, 64'(job_done), 64'd0);
        chk({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n;
        int jd0;
        rst = 1'b1;
        start = 1'b0;
        cal_importance = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_arr_rst_n", 64'(arr_rst_n), 64'd1);
        chk("rst_ctrl", 64'({arr_en, arr_cal_imp, res_valid, busy, job_done, err}), 64'd0);
        chk("rst_idx", 64'({tile_row, tile_col, res_row, res_col}), 64'd0);
        chk("rst_data", res_data, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed tile: rows [1,2,3,4]/[5,6,7,8], B all ones -> {26,26,10,10}.
        for (int m = 0; m < 4; m++)
            for (int k = 0; k < 4; k++) begin
                A[m][k] = (m % 2 == 0) ? k + 1 : k + 5;
                B[k][m] = 1;
            end
        for (int t = 0; t < 4; t++) begin
            exp_t e;
            e.data = 64'h001A_001A_000A_000A;
            e.imp  = 16'd72;
            e.row  = 4'(t / 2);
            e.col  = 4'(t % 2);
            exp_q.push_back(e);
        end
        ready_mode = 0;
        do_start(1'b1);
        lat = 0;
        while (!res_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", 64'(lat), 64'd7);
        chk("cal_latched", 64'(arr_cal_imp), 64'd1);
        wait_job_done("directed");

        // Random data, no importance, random backpressure, start noise.
        rand_mats();
        push_job(1'b0);
        ready_mode = 1;
        start_noise = 1;
        do_start(1'b0);
        wait_job_done("rand_noimp");
        start_noise = 0;
        start = 1'b0;

        // Importance latched at start; toggling mid-job must not matter.
        rand_mats();
        push_job(1'b1);
        cal_noise = 1;
        do_start(1'b1);
        wait_job_done("rand_imp");
        cal_noise = 0;

        // Long stall on tile (0,1).
        rand_mats();
        push_job(1'b1);
        ready_mode = 2;
        release_stall = 0;
        do_start(1'b1);
        n = 0;
        while (!(res_valid && res_row == 4'd0 && res_col == 4'd1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("stall_reached", 64'(res_valid), 64'd1);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("stall_en", 64'({arr_en, arr_done}), 64'd0);
            chk("stall_tile", 64'({tile_row, tile_col, res_valid}), 64'({4'd0, 4'd1, 1'b1}));
        end
        release_stall = 1;
        wait_job_done("stall");
        ready_mode = 1;

        // Missing done -> sticky err, no tile, no job_done.
        suppress_done = 1;
        jd0 = jd_count;
        do_start(1'b0);
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        chk("err_set", 64'(err), 64'd1);
        chk("err_idle", 64'({busy, res_valid}), 64'd0);
        chk("err_no_job_done", 64'(jd_count), 64'(jd0));
        suppress_done = 0;
        rand_mats();
        push_job(1'b0);
        do_start(1'b0);
        @(negedge clk);
        chk("err_cleared", 64'(err), 64'd0);
        wait_job_done("after_err");

        // Asynchronous reset during RUN of tile (1,0), with start noise.
        rand_mats();
        push_job(1'b1);
        ready_mode = 0;
        start_noise = 1;
        do_start(1'b1);
        n = 0;
        while (!(arr_en && tile_row == 4'd1 && tile_col == 4'd0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("reset_point_reached", 64'(arr_en), 64'd1);
        start_noise = 0;
        #2;
        start = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("arst_ctrl", 64'({arr_en, arr_cal_imp, res_valid, busy, job_done, err}), 64'd0);
        chk("arst_arr_rst_n", 64'(arr_rst_n), 64'd1);
        chk("arst_idx", 64'({tile_row, tile_col, res_row, res_col}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        rand_mats();
        push_job(1'b0);
        ready_mode = 1;
        do_start(1'b0);
        wait_job_done("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
